// File: rtl/dvfs_clock_controller.sv
// DVFS clock controller: maps opcodes to performance levels and
// sequences divider-select changes behind a core stall handshake.
module dvfs_clock_controller #(
    parameter int SETTLE_CYCLES = 4,
    parameter int DOWN_HOLD     = 8,
    parameter int MIN_DWELL     = 16,
    parameter int ACK_TIMEOUT   = 32
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic [2:0] opcode,
    input  logic       opcode_valid,
    input  logic       stall_ack,
    output logic       stall_req,
    output logic [1:0] div_sel,
    output logic       busy,
    output logic [7:0] switch_count,
    output logic       timeout_err
);

    typedef enum logic [1:0] {IDLE, STALL, SWITCH, DWELL} state_t;

    localparam int CMAX0 = (ACK_TIMEOUT > MIN_DWELL) ? ACK_TIMEOUT : MIN_DWELL;
    localparam int CMAX  = (CMAX0 > SETTLE_CYCLES) ? CMAX0 : SETTLE_CYCLES;
    localparam int CW    = $clog2(CMAX) + 1;
    localparam int DW    = $clog2(DOWN_HOLD) + 1;

    state_t         state, state_n;
    logic [1:0]     tgt, tgt_n;
    logic [1:0]     div_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [DW-1:0]  down_cnt, down_n;
    logic [7:0]     sw_n;
    logic           terr_n;

    function automatic logic [1:0] lvl(input logic [2:0] op);
        logic [1:0] l;
        l = 2'd0;
        unique case (1'b1)
            (op == 3'b100):                    l = 2'd2;
            (op == 3'b000) || (op == 3'b001):  l = 2'd1;
            default:                           l = 2'd0;
        endcase
        return l;
    endfunction

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            tgt          <= 2'd0;
            div_sel      <= 2'd0;
            cnt          <= '0;
            down_cnt     <= '0;
            switch_count <= 8'd0;
            timeout_err  <= 1'b0;
        end else begin
            state        <= state_n;
            tgt          <= tgt_n;
            div_sel      <= div_n;
            cnt          <= cnt_n;
            down_cnt     <= down_n;
            switch_count <= sw_n;
            timeout_err  <= terr_n;
        end
    end

    always_comb begin
        state_n = state;
        tgt_n   = opcode_valid ? lvl(opcode) : tgt;
        div_n   = div_sel;
        cnt_n   = cnt;
        down_n  = down_cnt;
        sw_n    = switch_count;
        terr_n  = timeout_err;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (tgt > div_sel) begin
                    state_n = STALL;
                    down_n  = '0;
                end else if (tgt < div_sel) begin
                    if (down_cnt == DW'(DOWN_HOLD - 1)) begin
                        state_n = STALL;
                        down_n  = '0;
                    end else begin
                        down_n = down_cnt + 1'b1;
                    end
                end else begin
                    down_n = '0;
                end
            end
            STALL: begin
                // ack wins over a timeout landing on the same edge
                if (stall_ack) begin
                    cnt_n = '0;
                    if (tgt == div_sel) begin
                        state_n = IDLE;
                    end else begin
                        div_n   = tgt;
                        state_n = SWITCH;
                    end
                end else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
                    state_n = IDLE;
                    terr_n  = 1'b1;
                    cnt_n   = '0;
                    down_n  = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            SWITCH: begin
                if (cnt == CW'(SETTLE_CYCLES - 1)) begin
                    state_n = DWELL;
                    cnt_n   = '0;
                    if (switch_count != 8'hFF)
                        sw_n = switch_count + 8'd1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DWELL: begin
                down_n = '0;
                if (cnt == CW'(MIN_DWELL - 1)) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign stall_req = (state == STALL) || (state == SWITCH);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_dvfs_clock_controller.sv
// Directed bench for dvfs_clock_controller: vector table for the
// main switch sequences plus hand-written timeout/revert/reset cases.
module tb_dvfs_clock_controller;

    logic       clk_in = 1'b0;
    logic       reset;
    logic [2:0] opcode;
    logic       opcode_valid;
    logic       stall_ack;
    logic       stall_req;
    logic [1:0] div_sel;
    logic       busy;
    logic [7:0] switch_count;
    logic       timeout_err;

    int total = 0;
    int bad   = 0;

    dvfs_clock_controller dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .opcode       (opcode),
        .opcode_valid (opcode_valid),
        .stall_ack    (stall_ack),
        .stall_req    (stall_req),
        .div_sel      (div_sel),
        .busy         (busy),
        .switch_count (switch_count),
        .timeout_err  (timeout_err)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [2:0] op;
        logic       v;
        logic       a;
        int         rep;
        logic       sr;
        logic [1:0] ds;
        logic       bs;
        int         swc;
    } vec_t;

    vec_t tbl[$];

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic sr, input logic [1:0] ds,
                           input logic bs, input int swc);
        chk({tag, ".stall_req"}, int'(stall_req), int'(sr));
        chk({tag, ".div_sel"}, int'(div_sel), int'(ds));
        chk({tag, ".busy"}, int'(busy), int'(bs));
        chk({tag, ".switch_count"}, int'(switch_count), swc);
    endtask

    initial begin
        int n;
        // T1: up 0->1, ack held high
        tbl.push_back('{3'd0, 1'b1, 1'b1, 1,  1'b0, 2'd0, 1'b0, 0});
        tbl.push_back('{3'd0, 1'b1, 1'b1, 1,  1'b1, 2'd0, 1'b1, 0});
        tbl.push_back('{3'd0, 1'b1, 1'b1, 1,  1'b1, 2'd1, 1'b1, 0});
        tbl.push_back('{3'd0, 1'b1, 1'b1, 3,  1'b1, 2'd1, 1'b1, 0});
        tbl.push_back('{3'd0, 1'b1, 1'b1, 1,  1'b0, 2'd1, 1'b1, 1});
        tbl.push_back('{3'd0, 1'b1, 1'b1, 15, 1'b0, 2'd1, 1'b1, 1});
        tbl.push_back('{3'd0, 1'b1, 1'b1, 1,  1'b0, 2'd1, 1'b0, 1});
        // T2: up 1->2, ack delayed 5 cycles
        tbl.push_back('{3'd4, 1'b1, 1'b0, 1,  1'b0, 2'd1, 1'b0, 1});
        tbl.push_back('{3'd4, 1'b0, 1'b0, 1,  1'b1, 2'd1, 1'b1, 1});
        tbl.push_back('{3'd4, 1'b0, 1'b0, 4,  1'b1, 2'd1, 1'b1, 1});
        tbl.push_back('{3'd4, 1'b0, 1'b1, 1,  1'b1, 2'd2, 1'b1, 1});
        tbl.push_back('{3'd4, 1'b0, 1'b0, 3,  1'b1, 2'd2, 1'b1, 1});
        tbl.push_back('{3'd4, 1'b0, 1'b0, 1,  1'b0, 2'd2, 1'b1, 2});
        tbl.push_back('{3'd4, 1'b0, 1'b0, 15, 1'b0, 2'd2, 1'b1, 2});
        tbl.push_back('{3'd4, 1'b0, 1'b0, 1,  1'b0, 2'd2, 1'b0, 2});
        // T3: down hysteresis, interrupted by a MUL pulse, then full count
        tbl.push_back('{3'd1, 1'b1, 1'b0, 1,  1'b0, 2'd2, 1'b0, 2});
        tbl.push_back('{3'd1, 1'b0, 1'b0, 3,  1'b0, 2'd2, 1'b0, 2});
        tbl.push_back('{3'd4, 1'b1, 1'b0, 1,  1'b0, 2'd2, 1'b0, 2});
        tbl.push_back('{3'd1, 1'b1, 1'b0, 1,  1'b0, 2'd2, 1'b0, 2});
        tbl.push_back('{3'd1, 1'b0, 1'b0, 7,  1'b0, 2'd2, 1'b0, 2});
        tbl.push_back('{3'd1, 1'b0, 1'b0, 1,  1'b1, 2'd2, 1'b1, 2});
        tbl.push_back('{3'd1, 1'b0, 1'b1, 1,  1'b1, 2'd1, 1'b1, 2});
        tbl.push_back('{3'd1, 1'b0, 1'b0, 3,  1'b1, 2'd1, 1'b1, 2});
        tbl.push_back('{3'd1, 1'b0, 1'b0, 1,  1'b0, 2'd1, 1'b1, 3});
        tbl.push_back('{3'd1, 1'b0, 1'b0, 15, 1'b0, 2'd1, 1'b1, 3});
        tbl.push_back('{3'd1, 1'b0, 1'b0, 1,  1'b0, 2'd1, 1'b0, 3});

        reset        = 1'b0;
        opcode       = 3'd0;
        opcode_valid = 1'b1;
        stall_ack    = 1'b1;
        tick();
        tick();
        chk_all("reset", 1'b0, 2'd0, 1'b0, 0);
        chk("reset.timeout_err", int'(timeout_err), 0);
        reset = 1'b1;

        foreach (tbl[i]) begin
            opcode       = tbl[i].op;
            opcode_valid = tbl[i].v;
            stall_ack    = tbl[i].a;
            for (int k = 0; k < tbl[i].rep; k++) tick();
            chk_all($sformatf("vec%0d", i), tbl[i].sr, tbl[i].ds, tbl[i].bs, tbl[i].swc);
        end

        // T5: target reverts to current level while stalled
        opcode = 3'd4; opcode_valid = 1'b1; stall_ack = 1'b0;
        tick();
        opcode = 3'd0;
        tick();
        chk("revert.stall", int'(stall_req), 1);
        opcode_valid = 1'b0; stall_ack = 1'b1;
        tick();
        chk_all("revert", 1'b0, 2'd1, 1'b0, 3);
        stall_ack = 1'b0;

        // T4: ack never arrives -> timeout, sticky error, retry
        opcode = 3'd4; opcode_valid = 1'b1;
        tick();
        opcode_valid = 1'b0;
        tick();
        n = 0;
        while (stall_req && n < 40) begin
            n++;
            tick();
        end
        chk("timeout.high_cycles", n, 32);
        chk("timeout.err", int'(timeout_err), 1);
        chk("timeout.div_sel", int'(div_sel), 1);
        chk("timeout.busy", int'(busy), 0);
        tick();
        chk("retry.stall", int'(stall_req), 1);
        stall_ack = 1'b1;
        tick();
        chk("retry.div_sel", int'(div_sel), 2);
        stall_ack = 1'b0;
        tick();
        chk("retry.err_sticky", int'(timeout_err), 1);

        // T6: asynchronous reset in the middle of SWITCH
        #2;
        reset = 1'b0;
        #1;
        chk_all("async_rst", 1'b0, 2'd0, 1'b0, 0);
        chk("async_rst.timeout_err", int'(timeout_err), 0);
        tick();
        reset = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
